// File: rtl/image_stream_loader.sv
// Stream-to-buffer loader for one DATA_X x DATA_Y image frame with a registered random-access read port.
// Optional running pixel checksum output when LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module image_stream_loader #(
  parameter int DATA_X    = 28,
  parameter int DATA_Y    = 28,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 frame_valid,
  input  logic                 frame_release,
  input  logic [4:0]           rd_x,
  input  logic [4:0]           rd_y,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 len_err,
  input  logic                 err_clear,
  output logic [7:0]           frame_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);
  localparam int DEPTH = DATA_X * DATA_Y;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(DATA_X);
  localparam int CW    = $clog2(DATA_Y);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t                r_state;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic [DATA_SIZE-1:0]  r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_last_slot;
  logic                  w_short;
  logic                  w_rd_oob;
  logic [AW-1:0]         w_wr_addr;
  logic [AW-1:0]         w_rd_addr;

  assign in_ready    = (r_state != FULL);
  assign w_accept    = in_valid & in_ready;
  assign w_last_slot = (r_row == RW'(DATA_X-1)) && (r_col == CW'(DATA_Y-1));
  assign w_short     = w_accept & in_last & ~w_last_slot;
  assign w_wr_addr   = AW'(r_row) * AW'(DATA_Y) + AW'(r_col);
  assign w_rd_addr   = AW'(rd_x) * AW'(DATA_Y) + AW'(rd_y);
  assign w_rd_oob    = (32'(rd_x) >= DATA_X) || (32'(rd_y) >= DATA_Y);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_col       <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
    end else begin
      case (r_state)
        IDLE, LOAD: begin
          if (w_accept) begin
            if (w_last_slot) begin
              r_row       <= '0;
              r_col       <= '0;
              r_state     <= FULL;
              frame_valid <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end else if (in_last) begin
              // Short frame: drop it, written pixels stay in the buffer
              r_row   <= '0;
              r_col   <= '0;
              r_state <= IDLE;
            end else begin
              r_state <= LOAD;
              if (r_col == CW'(DATA_Y-1)) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end
        FULL: begin
          if (frame_release) begin
            r_state     <= IDLE;
            frame_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      len_err <= 1'b0;
    else if (w_short || (w_accept && w_last_slot && !in_last))
      len_err <= 1'b1;
    else if (err_clear)
      len_err <= 1'b0;
  end

  // Buffer has no reset; simultaneous read of a written address sees the old word
  always_ff @(posedge clk) begin
    if (w_accept)
      r_mem[w_wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_data <= '0;
    else if (w_rd_oob)
      rd_data <= '0;
    else
      rd_data <= r_mem[w_rd_addr];
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] w_pix32;
  assign w_pix32 = 32'(in_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      checksum <= '0;
    else if (w_short)
      checksum <= '0;
    else if (w_accept) begin
      if (r_row == '0 && r_col == '0)
        checksum <= w_pix32;
      else
        checksum <= checksum + w_pix32;
    end
  end
`endif

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed bench for image_stream_loader: full, gapped, short and unterminated frames, release and mid-frame reset.
`timescale 1ns/1ps
module tb_image_stream_loader;
  localparam int DX = 28, DY = 28, DS = 32, NPIX = DX * DY;

  logic          clk = 1'b0, rst = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, frame_release = 1'b0, err_clear = 1'b0;
  logic [DS-1:0] in_data = '0;
  logic [4:0]    rd_x = '0, rd_y = '0;
  logic          in_ready, frame_valid, len_err;
  logic [DS-1:0] rd_data;
  logic [7:0]    frame_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int n_chk = 0, n_fail = 0;
  logic [31:0] d;

  image_stream_loader #(.DATA_X(DX), .DATA_Y(DY), .DATA_SIZE(DS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .frame_valid(frame_valid), .frame_release(frame_release),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .len_err(len_err), .err_clear(err_clear),
    .frame_count(frame_count)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one pixel from a negedge and return at the negedge after it is taken
  task automatic send(input int val, input bit last);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = DS'(val); in_last = last;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic frame(input int base, input int n, input int last_k, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin in_valid = 1'b0; @(negedge clk); end
      send(base + k, k == last_k);
      if (k == NPIX - 2) chk("fv_before_last", {31'd0, frame_valid}, 32'd0);
    end
  endtask

  task automatic rd(input int x, input int y, output logic [31:0] v);
    rd_x = 5'(x); rd_y = 5'(y);
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic check_all(input int base);
    int bad;
    logic [31:0] v;
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      rd(i / DY, i % DY, v);
      if (v !== 32'(base + i)) bad++;
    end
    chk("buf_bad_words", 32'(bad), 32'd0);
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_len_err", {31'd0, len_err}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back full frame, pixel k = k
    frame(0, NPIX, NPIX - 1, 1'b0);
    chk("f1_in_ready", {31'd0, in_ready}, 32'd0);
    chk("f1_frame_valid", {31'd0, frame_valid}, 32'd1);
    chk("f1_frame_count", 32'(frame_count), 32'd1);
    chk("f1_len_err", {31'd0, len_err}, 32'd0);
    rd(27, 27, d); chk("f1_rd_27_27", d, 32'd783);
    rd(1, 0, d);   chk("f1_rd_1_0", d, 32'd28);
    rd(13, 5, d);  chk("f1_rd_13_5", d, 32'd369);
    rd(28, 0, d);  chk("f1_rd_oob_x", d, 32'd0);
    rd(0, 31, d);  chk("f1_rd_oob_y", d, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("f1_checksum", checksum, 32'd306936);
`endif

    // Held valid in FULL: nothing is accepted
    in_valid = 1'b1; in_data = 32'd9999; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    rd(0, 0, d); chk("full_no_write", d, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("full_checksum_frozen", checksum, 32'd306936);
`endif
    release_frame();
    chk("rel_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rd(0, 0, d); chk("rel_first_pixel", d, 32'd9999);
    chk("rel_frame_count", 32'(frame_count), 32'd1);

    // Short frame: pixel 0 already taken, finish with in_last on k=99
    for (int k = 1; k < 100; k++) send(1000 + k, k == 99);
    chk("sh_len_err", {31'd0, len_err}, 32'd1);
    chk("sh_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("sh_frame_count", 32'(frame_count), 32'd1);
    chk("sh_in_ready", {31'd0, in_ready}, 32'd1);
    rd(3, 15, d); chk("sh_last_written", d, 32'd1099);
`ifdef LOADER_CHECKSUM_EN
    chk("sh_checksum", checksum, 32'd0);
`endif
    err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
    chk("clr_len_err", {31'd0, len_err}, 32'd0);

    // Gapped full frame must start at (0,0) and match the first frame
    frame(0, NPIX, NPIX - 1, 1'b1);
    chk("g_frame_valid", {31'd0, frame_valid}, 32'd1);
    chk("g_frame_count", 32'(frame_count), 32'd2);
    chk("g_len_err", {31'd0, len_err}, 32'd0);
    check_all(0);
`ifdef LOADER_CHECKSUM_EN
    chk("g_checksum", checksum, 32'd306936);
`endif
    release_frame();

    // Full-length frame without in_last still completes but flags an error
    frame(100, NPIX, -1, 1'b0);
    chk("nl_frame_valid", {31'd0, frame_valid}, 32'd1);
    chk("nl_len_err", {31'd0, len_err}, 32'd1);
    chk("nl_frame_count", 32'(frame_count), 32'd3);
    rd(27, 27, d); chk("nl_rd_27_27", d, 32'd883);
    release_frame();

    // Reset after 300 accepts
    frame(5000, 300, -1, 1'b0);
    chk("pre_rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("mrst_len_err", {31'd0, len_err}, 32'd0);
    chk("mrst_rd_data", rd_data, 32'd0);
    chk("mrst_frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    frame(0, NPIX, NPIX - 1, 1'b0);
    chk("r_frame_valid", {31'd0, frame_valid}, 32'd1);
    chk("r_frame_count", 32'(frame_count), 32'd1);
    check_all(0);
`ifdef LOADER_CHECKSUM_EN
    chk("r_checksum", checksum, 32'd306936);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
